// File: rtl/led_water_pkg.sv
// Shared constants for the multi-pattern LED water light.
// Pattern selector encodings and ping-pong direction values.
package led_water_pkg;

   localparam logic [1:0] MODE_ROL  = 2'd0;
   localparam logic [1:0] MODE_ROR  = 2'd1;
   localparam logic [1:0] MODE_PP   = 2'd2;
   localparam logic [1:0] MODE_FILL = 2'd3;

   localparam logic DIR_L = 1'b0;
   localparam logic DIR_R = 1'b1;

endpackage

// File: rtl/led_water_multi_tick_gen.sv
// Step prescaler: counts enabled cycles and flags the last one of each MAXS-cycle step.
// clr restarts the count so a new pattern gets a full first step.
module tick_gen #(
   parameter int MAXS = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = (MAXS > 1) ? $clog2(MAXS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAXS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] cnt_r;

   assign tick = en && !clr && (cnt_r == CNT_LAST);

   // Prescaler counter: wraps on the last cycle, holds while paused.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (clr) begin
         cnt_r <= '0;
      end else if (en) begin
         if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
         end else begin
            cnt_r <= cnt_r + CNT_ONE;
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/led_water_multi.sv
// Parametrised LED water light: rotate left/right, ping-pong and bar fill patterns,
// advanced once per prescaled step, with a registered step strobe for chaining.
import led_water_pkg::*;

module led_water_multi #(
   parameter int LED_N = 8,
   parameter int MAXS  = 50_000_000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       mode,
   output logic [LED_N-1:0] led_on,
   output logic             step_tick
);

   localparam logic [LED_N-1:0] LED_ONE = {{(LED_N-1){1'b0}}, 1'b1};

   logic [1:0]       mode_q_r;
   logic             dir_r;
   logic             mode_chg_s;
   logic             tick_s;
   logic [LED_N-1:0] led_nxt_s;
   logic             dir_nxt_s;

   function automatic logic is_onehot(input logic [LED_N-1:0] v);
      return (v != '0) && ((v & (v - LED_ONE)) == '0);
   endfunction

   assign mode_chg_s = (mode != mode_q_r);

   tick_gen #(.MAXS(MAXS)) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .clr   (mode_chg_s),
      .tick  (tick_s)
   );

   // Next pattern value; non-one-hot states in the single-dot modes restart from bit 0.
   always_comb begin
      led_nxt_s = LED_ONE;
      dir_nxt_s = dir_r;
      case (mode_q_r)
         MODE_ROL: begin
            if (is_onehot(led_on)) begin
               led_nxt_s = {led_on[LED_N-2:0], led_on[LED_N-1]};
            end else begin
               led_nxt_s = LED_ONE;
            end
         end
         MODE_ROR: begin
            if (is_onehot(led_on)) begin
               led_nxt_s = {led_on[0], led_on[LED_N-1:1]};
            end else begin
               led_nxt_s = LED_ONE;
            end
         end
         MODE_PP: begin
            if (!is_onehot(led_on)) begin
               led_nxt_s = LED_ONE;
               dir_nxt_s = DIR_L;
            end else if (dir_r == DIR_L) begin
               // Bounce off the top end without dwelling there.
               if (led_on[LED_N-1]) begin
                  led_nxt_s = led_on >> 1;
                  dir_nxt_s = DIR_R;
               end else begin
                  led_nxt_s = led_on << 1;
                  dir_nxt_s = DIR_L;
               end
            end else begin
               if (led_on[0]) begin
                  led_nxt_s = led_on << 1;
                  dir_nxt_s = DIR_L;
               end else begin
                  led_nxt_s = led_on >> 1;
                  dir_nxt_s = DIR_R;
               end
            end
         end
         MODE_FILL: begin
            if (&led_on) begin
               led_nxt_s = LED_ONE;
            end else begin
               led_nxt_s = {led_on[LED_N-2:0], 1'b1};
            end
         end
         default: begin
            led_nxt_s = LED_ONE;
            dir_nxt_s = DIR_L;
         end
      endcase
   end

   // Pattern state: reset and mode change both restart the pattern; otherwise step on tick.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         led_on    <= LED_ONE;
         dir_r     <= DIR_L;
         step_tick <= 1'b0;
         mode_q_r  <= mode;
      end else if (mode_chg_s) begin
         led_on    <= LED_ONE;
         dir_r     <= DIR_L;
         step_tick <= 1'b0;
         mode_q_r  <= mode;
      end else if (tick_s) begin
         led_on    <= led_nxt_s;
         dir_r     <= dir_nxt_s;
         step_tick <= 1'b1;
         mode_q_r  <= mode_q_r;
      end else begin
         led_on    <= led_on;
         dir_r     <= dir_r;
         step_tick <= 1'b0;
         mode_q_r  <= mode_q_r;
      end
   end

endmodule

// File: tb/tb_led_water_multi.sv
// Self-checking bench for led_water_multi (LED_N=4, MAXS=5): step-count model checked
// every cycle, plus hand-computed pattern values along the directed scenarios.
`timescale 1ns/1ps

module tb_led_water_multi;

   localparam int N  = 4;
   localparam int MS = 5;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         en;
   logic [1:0]   mode;
   logic [N-1:0] led_on;
   logic         step_tick;

   int n_cmp = 0;
   int n_err = 0;

   // Model: steps taken since the pattern last restarted, plus the prescaler count.
   int   m_cnt   = 0;
   int   m_steps = 0;
   int   m_mode  = 0;
   logic m_st    = 1'b0;
   logic m_valid = 1'b0;

   led_water_multi #(.LED_N(N), .MAXS(MS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .mode      (mode),
      .led_on    (led_on),
      .step_tick (step_tick)
   );

   always #1 clk = ~clk;

   always @(posedge clk) begin
      if (!rst_n || (int'(mode) != m_mode)) begin
         m_cnt   <= 0;
         m_steps <= 0;
         m_mode  <= int'(mode);
         m_st    <= 1'b0;
         m_valid <= 1'b1;
      end else if (en) begin
         if (m_cnt == MS - 1) begin
            m_cnt   <= 0;
            m_steps <= m_steps + 1;
            m_st    <= 1'b1;
         end else begin
            m_cnt <= m_cnt + 1;
            m_st  <= 1'b0;
         end
      end else begin
         m_st <= 1'b0;
      end
   end

   // Pattern after s steps, straight from each pattern's closed form.
   function automatic logic [N-1:0] pattern_at(input int md, input int s);
      int t;
      int per;
      int pos;
      case (md)
         0: pattern_at = N'(1 << (s % N));
         1: pattern_at = N'(1 << ((N - (s % N)) % N));
         2: begin
            per = 2 * (N - 1);
            t   = s % per;
            pos = (t < N) ? t : per - t;
            pattern_at = N'(1 << pos);
         end
         default: begin
            t = s % N;
            pattern_at = N'((1 << (t + 1)) - 1);
         end
      endcase
   endfunction

   task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Advance n cycles, comparing DUT against the model at each falling edge.
   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (m_valid) begin
            check("model_led", led_on, pattern_at(m_mode, m_steps));
            check("model_step", N'(step_tick), N'(m_st));
         end
      end
   endtask

   task automatic restart(input logic [1:0] md);
      rst_n = 1'b0;
      mode  = md;
      en    = 1'b1;
      cyc(1);
      rst_n = 1'b1;
   endtask

   logic [N-1:0] pp_seq [8];
   logic [N-1:0] fill_seq [5];

   initial begin
      pp_seq   = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100};
      fill_seq = '{4'b0011, 4'b0111, 4'b1111, 4'b0001, 4'b0011};
      rst_n = 1'b0;
      en    = 1'b0;
      mode  = 2'd0;
      cyc(2);
      check("reset_led", led_on, 4'b0001);
      check("reset_step", N'(step_tick), 4'b0000);

      // Rotate left: first step after exactly MAXS enabled cycles.
      rst_n = 1'b1;
      en    = 1'b1;
      cyc(4);
      check("rol_before_first", led_on, 4'b0001);
      cyc(1);
      check("rol_step1", led_on, 4'b0010);
      check("rol_tick1", N'(step_tick), 4'b0001);
      cyc(1);
      check("rol_tick_low", N'(step_tick), 4'b0000);
      cyc(14);
      check("rol_wrap", led_on, 4'b0001);

      // Rotate right.
      restart(2'd1);
      cyc(5);
      check("ror_step1", led_on, 4'b1000);
      cyc(5);
      check("ror_step2", led_on, 4'b0100);

      // Ping-pong: no dwell at either end.
      restart(2'd2);
      for (int k = 0; k < 8; k++) begin
         cyc(5);
         check("pp_seq", led_on, pp_seq[k]);
      end

      // Bar fill.
      restart(2'd3);
      for (int k = 0; k < 5; k++) begin
         cyc(5);
         check("fill_seq", led_on, fill_seq[k]);
      end

      // Pause at cnt=3 with 0100 lit, then resume.
      restart(2'd0);
      cyc(13);
      check("pause_pre", led_on, 4'b0100);
      en = 1'b0;
      cyc(12);
      check("pause_hold", led_on, 4'b0100);
      check("pause_step", N'(step_tick), 4'b0000);
      en = 1'b1;
      cyc(1);
      check("resume_wait", led_on, 4'b0100);
      cyc(1);
      check("resume_step", led_on, 4'b1000);
      check("resume_tick", N'(step_tick), 4'b0001);

      // Mode change 0->2 at cnt=3 with 1000 lit.
      cyc(3);
      mode = 2'd2;
      cyc(1);
      check("mchg_led", led_on, 4'b0001);
      check("mchg_step", N'(step_tick), 4'b0000);
      cyc(4);
      check("mchg_wait", led_on, 4'b0001);
      cyc(1);
      check("mchg_first_pp", led_on, 4'b0010);

      // Mode change while paused still restarts the pattern.
      cyc(5);
      en   = 1'b0;
      mode = 2'd3;
      cyc(3);
      check("mchg_paused", led_on, 4'b0001);
      mode = 2'd2;
      en   = 1'b1;
      cyc(1);

      // Reset on a tick cycle wins over the step.
      cyc(4);
      rst_n = 1'b0;
      cyc(1);
      check("rst_tick_led", led_on, 4'b0001);
      check("rst_tick_step", N'(step_tick), 4'b0000);
      rst_n = 1'b1;
      cyc(5);
      check("rst_after", led_on, 4'b0010);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
